// File: rtl/spmv_vec_lookup.sv
// spmv_vec_lookup
//   Feeder for the mac stage. It holds the dense vector x in on-chip RAM,
//   accepts the streamed sparse-matrix entries (row, col, value) and pairs each
//   value with x[col]. The pair leaves on wr/row/v0/v1 exactly two cycles after
//   the entry is accepted. One eof pulse is issued per matrix once the
//   pipeline has drained.
//
// Ports
//   clk, rst           clock (posedge) and synchronous active-high reset
//   start_load         pulse, IDLE -> LOAD; clears err_oob and beat_count
//   vec_wr/addr/data   vector RAM write port, honoured in LOAD only
//   load_done          pulse, LOAD -> RUN (a same-cycle vec_wr still lands)
//   in_valid/in_ready  entry stream; an entry moves when both are high
//   in_row/col/val     entry payload
//   in_eof             last entry of the matrix, with or without in_valid
//   wr/row/v0/v1       beat to mac; row/v0/v1 hold their values while wr=0
//   eof                one-cycle end-of-matrix pulse to mac
//   busy               state != IDLE
//   err_oob            sticky: an accepted entry had in_col >= VECTOR_DEPTH
//   beat_count         beats emitted since the last start_load (wraps)
//   state              current FSM state, for observation
//
// Handshake: in_valid and in_ready follow valid/ready rules. An entry is
// taken on a rising clock edge where both are high; in_ready depends only on
// the FSM state and never on in_valid. The producer keeps the entry stable
// until it is taken.

module spmv_vec_lookup #(
  parameter int VECTOR_DEPTH             = 1024,
  parameter int LOG2_VECTOR_DEPTH        = $clog2(VECTOR_DEPTH),
  parameter int INTERMEDIATOR_DEPTH      = 1024,
  parameter int LOG2_INTERMEDIATOR_DEPTH = $clog2(INTERMEDIATOR_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_load,
  input  logic                                vec_wr,
  input  logic [LOG2_VECTOR_DEPTH-1:0]        vec_addr,
  input  logic [63:0]                         vec_data,
  input  logic                                load_done,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] in_row,
  input  logic [31:0]                         in_col,
  input  logic [63:0]                         in_val,
  input  logic                                in_eof,
  output logic                                wr,
  output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
  output logic [63:0]                         v0,
  output logic [63:0]                         v1,
  output logic                                eof,
  output logic                                busy,
  output logic                                err_oob,
  output logic [31:0]                         beat_count,
  output logic [1:0]                          state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [63:0] ram [VECTOR_DEPTH];
  logic [63:0] ram_q;

  // Stage 1 carries the entry alongside the synchronous RAM read.
  logic                                s1_valid;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] s1_row;
  logic [63:0]                         s1_val;
  logic                                s1_oob;

  logic accept;
  logic oob;

  assign in_ready = (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid & in_ready;
  assign oob      = (in_col >= 32'(VECTOR_DEPTH));

  // Vector RAM: contents deliberately survive reset. The read runs every
  // cycle; the result is only consumed when stage 1 holds a valid beat.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && vec_wr) begin
      ram[vec_addr] <= vec_data;
    end
    ram_q <= ram[in_col[LOG2_VECTOR_DEPTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      s1_valid   <= 1'b0;
      s1_row     <= '0;
      s1_val     <= '0;
      s1_oob     <= 1'b0;
      wr         <= 1'b0;
      row        <= '0;
      v0         <= '0;
      v1         <= '0;
      eof        <= 1'b0;
      err_oob    <= 1'b0;
      beat_count <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_row <= in_row;
        s1_val <= in_val;
        s1_oob <= oob;
      end

      wr <= s1_valid;
      if (s1_valid) begin
        row        <= s1_row;
        v0         <= s1_val;
        v1         <= s1_oob ? 64'd0 : ram_q;
        beat_count <= beat_count + 32'd1;
      end

      if (accept && oob) begin
        err_oob <= 1'b1;
      end

      eof <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_load) begin
            state      <= S_LOAD;
            err_oob    <= 1'b0;
            beat_count <= '0;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_eof) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // With stage 1 empty, the beat now in the output register (if any)
          // is the last one, so eof lands in the cycle right after it.
          if (!s1_valid) begin
            eof   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_vec_lookup.sv
// Bench for spmv_vec_lookup: loads vectors, streams entries, and compares each
// wr beat (payload and cycle) against a queue of expected beats.

module tb_spmv_vec_lookup;

  localparam int VD = 1024;
  localparam int AW = 10;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load;
  logic          vec_wr;
  logic [AW-1:0] vec_addr;
  logic [63:0]   vec_data;
  logic          load_done;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic [31:0]   in_col;
  logic [63:0]   in_val;
  logic          in_eof;
  logic          wr;
  logic [RW-1:0] row;
  logic [63:0]   v0;
  logic [63:0]   v1;
  logic          eof;
  logic          busy;
  logic          err_oob;
  logic [31:0]   beat_count;
  logic [1:0]    state;

  spmv_vec_lookup #(
    .VECTOR_DEPTH(VD), .LOG2_VECTOR_DEPTH(AW),
    .INTERMEDIATOR_DEPTH(1024), .LOG2_INTERMEDIATOR_DEPTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .vec_wr(vec_wr),
    .vec_addr(vec_addr), .vec_data(vec_data), .load_done(load_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_col(in_col), .in_val(in_val), .in_eof(in_eof), .wr(wr),
    .row(row), .v0(v0), .v1(v1), .eof(eof), .busy(busy),
    .err_oob(err_oob), .beat_count(beat_count), .state(state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0]  x_m [VD];
  logic [137:0] exp_q[$];
  int           exp_cyc_q[$];
  int           wr_total;
  int           eof_total;
  int           eof_cyc;
  int           last_wr_cyc;
  logic [137:0] mon_e;
  int           mon_ec;

  task automatic check_eq(input string tag, input logic [137:0] act, input logic [137:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_total++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", wr, 0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        check_eq("wr_data", {row, v0, v1}, mon_e);
        check_eq("wr_cycle", cyc, mon_ec);
      end
    end
    if (eof === 1'b1) begin
      eof_total++;
      eof_cyc = cyc;
      check_eq("eof_wr_low", wr, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    wr_total  = 0;
    eof_total = 0;
    eof_cyc   = -1;
  endtask

  task automatic do_start_load();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
  endtask

  task automatic write_x(input int addr, input logic [63:0] data, input logic done);
    vec_wr    = 1'b1;
    vec_addr  = AW'(addr);
    vec_data  = data;
    load_done = done;
    tick();
    vec_wr    = 1'b0;
    load_done = 1'b0;
    x_m[addr] = data;
  endtask

  task automatic beat(input int r, input int c, input logic [63:0] val, input logic last);
    logic [63:0] xv;
    xv = (c < VD) ? x_m[c] : 64'd0;
    in_valid = 1'b1;
    in_row   = RW'(r);
    in_col   = 32'(c);
    in_val   = val;
    in_eof   = last;
    exp_q.push_back({RW'(r), val, xv});
    exp_cyc_q.push_back(cyc + 2);
    tick();
    in_valid = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic wait_eof();
    int n0;
    n0 = eof_total;
    for (int i = 0; i < 60; i++) begin
      if (eof_total != n0) break;
      tick();
    end
    check_eq("eof_seen", eof_total != n0, 1);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int r_cyc;
    int t_cyc;
    rst = 1'b1; start_load = 0; vec_wr = 0; vec_addr = '0; vec_data = '0;
    load_done = 0; in_valid = 0; in_row = '0; in_col = '0; in_val = '0; in_eof = 0;
    clr_stats();
    repeat (3) tick();
    check_eq("rst_wr", wr, 0);
    check_eq("rst_eof", eof, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_err_oob", err_oob, 0);
    check_eq("rst_beat_count", beat_count, 0);
    check_eq("rst_outs", {row, v0, v1}, 0);
    rst = 1'b0;
    tick();

    // 1: load x[0..24], 25 back-to-back beats
    clr_stats();
    do_start_load();
    check_eq("t1_busy_load", busy, 1);
    for (int i = 0; i < 25; i++) write_x(i, rand64(), i == 24);
    check_eq("t1_in_ready_run", in_ready, 1);
    for (int i = 0; i < 25; i++) beat(i, $urandom_range(0, 24), rand64(), i == 24);
    wait_eof();
    check_eq("t1_wr_total", wr_total, 25);
    check_eq("t1_eof_after_last_wr", eof_cyc, last_wr_cyc + 1);
    check_eq("t1_busy_after", busy, 0);
    check_eq("t1_beat_count", beat_count, 25);
    check_eq("t1_err_oob", err_oob, 0);

    // 2: out-of-range column
    clr_stats();
    do_start_load();
    write_x(0, rand64(), 1'b1);
    beat(3, 1024, rand64(), 1'b1);
    wait_eof();
    check_eq("t2_wr_total", wr_total, 1);
    check_eq("t2_err_oob", err_oob, 1);
    repeat (2) tick();
    check_eq("t2_err_oob_sticky", err_oob, 1);
    do_start_load();
    check_eq("t2_err_oob_cleared", err_oob, 0);
    check_eq("t2_beat_count_cleared", beat_count, 0);

    // 3: eof with no beats
    clr_stats();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    in_eof = 1'b1;
    t_cyc = cyc;
    tick();
    in_eof = 1'b0;
    wait_eof();
    check_eq("t3_eof_cycle", eof_cyc, t_cyc + 2);
    check_eq("t3_no_wr", wr_total, 0);
    check_eq("t3_busy_after", busy, 0);

    // 4: in_valid during LOAD; vec_wr together with load_done
    clr_stats();
    do_start_load();
    in_valid = 1'b1; in_row = 10'd7; in_col = 32'd5; in_val = rand64();
    check_eq("t4_in_ready_load", in_ready, 0);
    write_x(4, rand64(), 1'b0);
    in_valid = 1'b0;
    write_x(5, rand64(), 1'b1);
    check_eq("t4_no_wr_in_load", wr_total, 0);
    beat(7, 5, rand64(), 1'b0);
    beat(8, 4, rand64(), 1'b1);
    wait_eof();
    check_eq("t4_wr_total", wr_total, 2);

    // 5: reset mid-run
    clr_stats();
    do_start_load();
    write_x(6, rand64(), 1'b1);
    for (int i = 0; i < 3; i++) beat(20 + i, i, rand64(), 1'b0);
    rst = 1'b1;
    r_cyc = cyc;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[exp_cyc_q.size()-1] > r_cyc) begin
      void'(exp_cyc_q.pop_back());
      void'(exp_q.pop_back());
    end
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check_eq("t5_wr_total", wr_total, 2);
    check_eq("t5_no_eof", eof_total, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_beat_count", beat_count, 0);
    check_eq("t5_queue_empty", exp_q.size(), 0);

    // 6: gapped input, 1 of 3 cycles
    clr_stats();
    do_start_load();
    write_x(9, rand64(), 1'b1);
    for (int i = 0; i < 10; i++) begin
      beat(i * 3, $urandom_range(0, 24), rand64(), i == 9);
      if (i < 9) repeat (2) tick();
    end
    wait_eof();
    check_eq("t6_wr_total", wr_total, 10);
    check_eq("t6_beat_count", beat_count, 10);
    check_eq("t6_eof_after_last_wr", eof_cyc, last_wr_cyc + 1);
    check_eq("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
